b_adder_lanes: RTL and testbench

//  Parametrised successor to the single-mode B-combiner in the encryption datapath.

---
 rtl/b_adder_lanes_if.sv | 35 +++
 rtl/b_adder_lanes.sv | 145 ++++++++++++++
 tb/tb_b_adder_lanes.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b_adder_lanes_if.sv
// Stream bundle for b_adder_lanes: product, error and key inputs, result output, status.
interface b_adder_lanes_if #(
  parameter int LANES  = 2,
  parameter int COEF_W = 18,
  parameter int IDX_W  = 10
);
  logic                             mode_in;
  logic                             poly_valid;
  logic [LANES:0][COEF_W-1:0]       poly_in;
  logic [IDX_W-1:0]                 poly_idx;
  logic                             poly_ready;
  logic                             e_valid;
  logic [LANES-1:0][COEF_W-1:0]     e_in;
  logic [IDX_W-1:0]                 e_idx;
  logic                             e_ready;
  logic                             b_valid;
  logic [LANES-1:0][COEF_W-1:0]     b_in;
  logic                             b_ready;
  logic                             sum_valid;
  logic [LANES-1:0][COEF_W-1:0]     sum;
  logic [IDX_W-1:0]                 sum_idx;
  logic                             sum_ready;
  logic                             poly_done;
  logic                             idx_err;

  modport master (
    output mode_in, poly_valid, poly_in, poly_idx, e_valid, e_in, e_idx, b_valid, b_in, sum_ready,
    input  poly_ready, e_ready, b_ready, sum_valid, sum, sum_idx, poly_done, idx_err
  );

  modport slave (
    input  mode_in, poly_valid, poly_in, poly_idx, e_valid, e_in, e_idx, b_valid, b_in, sum_ready,
    output poly_ready, e_ready, b_ready, sum_valid, sum, sum_idx, poly_done, idx_err
  );
endinterface

// File: rtl/b_adder_lanes.sv
// B-combiner: b +/- poly (+e) per beat with overlap carry into lane 0 of the next beat.
// Define NEGWRAP_EN to fold the final overlap lane back into beat 0 (X^N+1 wrap).
module b_adder_lane #(
  parameter int COEF_W = 18
) (
  input  logic              sub,
  input  logic [COEF_W-1:0] b,
  input  logic [COEF_W-1:0] p,
  input  logic [COEF_W-1:0] e,
  input  logic [COEF_W-1:0] c,
  output logic [COEF_W-1:0] r
);
  assign r = sub ? (b - p - c) : (b + p + e + c);
endmodule

module b_adder_lanes #(
  parameter int LANES  = 2,
  parameter int COEF_W = 18,
  parameter int DEPTH  = 100,
  parameter int IDX_W  = 10
) (
  input logic            clk_in,
  input logic            rst_n_in,
  b_adder_lanes_if.slave bus
);
  typedef logic [LANES-1:0][COEF_W-1:0] lanes_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef struct packed {
    lanes_t           lanes;
    logic [IDX_W-1:0] idx;
    logic             last;
  } out_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

  state_t            state;
  logic [IDX_W-1:0]  exp_idx;
  logic [COEF_W-1:0] carry;
  logic              mode_r;
  out_t              out_r;
  logic              sum_valid_r;
  logic              idx_err_r;

  logic              slot_free, join_ok, drain, idx_mis, first, is_last, cur_sub;
  logic [COEF_W-1:0] c_in;
  lanes_t            res;

  assign slot_free = !sum_valid_r || bus.sum_ready;
  assign first     = (state == IDLE);
  assign is_last   = (bus.poly_idx == LAST);
  // A fresh polynomial uses the live mode bit; later beats use the latched one.
  assign cur_sub   = first ? bus.mode_in : mode_r;
  assign c_in      = first ? '0 : carry;

  assign join_ok = rst_n_in && bus.poly_valid && bus.e_valid && bus.b_valid &&
                   (bus.poly_idx == bus.e_idx) && (bus.poly_idx == exp_idx) &&
                   slot_free && (state != FLUSH);
  assign drain   = rst_n_in && bus.poly_valid && (bus.poly_idx >= DEPTH_I) && slot_free;
  assign idx_mis = bus.poly_valid && bus.e_valid && (bus.poly_idx == bus.e_idx) &&
                   (bus.poly_idx < DEPTH_I) && (bus.poly_idx != exp_idx);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    b_adder_lane #(.COEF_W(COEF_W)) u_lane (
      .sub (cur_sub),
      .b   (bus.b_in[k]),
      .p   (bus.poly_in[k]),
      .e   (bus.e_in[k]),
      .c   ((k == 0) ? c_in : '0),
      .r   (res[k])
    );
  end

`ifdef NEGWRAP_EN
  lanes_t hold, hold_adj;

  // carry holds the overlap of beat DEPTH-1 while flushing.
  always_comb begin
    hold_adj    = hold;
    hold_adj[0] = mode_r ? (hold[0] + carry) : (hold[0] - carry);
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      exp_idx     <= '0;
      carry       <= '0;
      mode_r      <= 1'b0;
      out_r       <= '0;
      sum_valid_r <= 1'b0;
      idx_err_r   <= 1'b0;
`ifdef NEGWRAP_EN
      hold        <= '0;
`endif
    end else begin
      if (sum_valid_r && bus.sum_ready) sum_valid_r <= 1'b0;
      if (idx_mis) idx_err_r <= 1'b1;

      if (join_ok) begin
        carry <= bus.poly_in[LANES];
        if (first) mode_r <= bus.mode_in;
        if (is_last) begin
          exp_idx <= '0;
`ifdef NEGWRAP_EN
          state   <= FLUSH;
`else
          state   <= IDLE;
`endif
        end else begin
          exp_idx <= exp_idx + IDX_W'(1);
          state   <= RUN;
        end
`ifdef NEGWRAP_EN
        if (first) begin
          hold <= res;
        end else begin
          out_r       <= '{lanes: res, idx: bus.poly_idx, last: 1'b0};
          sum_valid_r <= 1'b1;
        end
`else
        out_r       <= '{lanes: res, idx: bus.poly_idx, last: is_last};
        sum_valid_r <= 1'b1;
`endif
      end

`ifdef NEGWRAP_EN
      if (state == FLUSH && slot_free) begin
        out_r       <= '{lanes: hold_adj, idx: '0, last: 1'b1};
        sum_valid_r <= 1'b1;
        state       <= IDLE;
      end
`endif
    end
  end

  assign bus.poly_ready = join_ok || drain;
  assign bus.e_ready    = join_ok;
  assign bus.b_ready    = join_ok;
  assign bus.sum_valid  = sum_valid_r;
  assign bus.sum        = out_r.lanes;
  assign bus.sum_idx    = out_r.idx;
  assign bus.poly_done  = sum_valid_r && bus.sum_ready && out_r.last;
  assign bus.idx_err    = idx_err_r;
endmodule

// File: tb/tb_b_adder_lanes.sv
// Bench for b_adder_lanes (LANES=2, COEF_W=18, DEPTH=4): scoreboard model plus directed literals.
module tb_b_adder_lanes;
  localparam int LANES = 2, COEF_W = 18, DEPTH = 4, IDX_W = 10;
  typedef logic [COEF_W-1:0] c_t;
  typedef struct { int idx; c_t l0; c_t l1; bit last; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  b_adder_lanes_if #(.LANES(LANES), .COEF_W(COEF_W), .IDX_W(IDX_W)) bus();
  b_adder_lanes #(.LANES(LANES), .COEF_W(COEF_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // Model state: expected output order, next expected index, wrap hold.
  exp_t q[$];
  exp_t held;
  int   exp_i = 0;
  bit   flush_blk = 0, m_err = 0, m_mode = 0;
  c_t   prev_top = '0;
  int   hs_cnt = 0, done_cnt = 0;
  int   ord_q[$];
  c_t   log_l0[DEPTH], log_l1[DEPTH];

  function automatic exp_t mk(input int idx, input c_t l0, input c_t l1, input bit last);
    exp_t x;
    x.idx = idx; x.l0 = l0; x.l1 = l1; x.last = last;
    return x;
  endfunction

  always @(negedge clk) begin : mon
    int pidx;
    bit slot, jn, dr, hs;
    c_t c, r0, r1, top;
    exp_t f;
    if (!rst_n) begin
      q.delete(); exp_i = 0; flush_blk = 0; m_err = 0; m_mode = 0; prev_top = '0;
    end else begin
      pidx = int'(bus.poly_idx);
      slot = (q.size() == 0) || bus.sum_ready;
      jn = bus.poly_valid && bus.e_valid && bus.b_valid && (bus.poly_idx == bus.e_idx) &&
           (pidx == exp_i) && slot && !flush_blk;
      dr = bus.poly_valid && (pidx >= DEPTH) && slot;
      chk("poly_ready", 32'(bus.poly_ready), 32'(jn || dr));
      chk("e_ready", 32'(bus.e_ready), 32'(jn));
      chk("b_ready", 32'(bus.b_ready), 32'(jn));
      chk("idx_err", 32'(bus.idx_err), 32'(m_err));
      chk("sum_valid", 32'(bus.sum_valid), 32'(q.size() > 0));
      if (bus.sum_valid && bus.sum_ready && bus.poly_done) done_cnt++;
      if (q.size() > 0) begin
        f = q[0];
        chk("sum_idx", 32'(bus.sum_idx), 32'(f.idx));
        chk("sum_lane0", 32'(bus.sum[0]), 32'(f.l0));
        chk("sum_lane1", 32'(bus.sum[1]), 32'(f.l1));
        hs = bus.sum_ready;
        chk("poly_done", 32'(bus.poly_done), 32'(hs && f.last));
        if (hs) begin
          hs_cnt++;
          ord_q.push_back(int'(bus.sum_idx));
          if (int'(bus.sum_idx) < DEPTH) begin
            log_l0[int'(bus.sum_idx)] = bus.sum[0];
            log_l1[int'(bus.sum_idx)] = bus.sum[1];
          end
`ifdef NEGWRAP_EN
          if (f.idx == DEPTH - 1) flush_blk = 0;
`endif
          void'(q.pop_front());
        end
      end else begin
        chk("poly_done_idle", 32'(bus.poly_done), 32'd0);
      end
      if (bus.poly_valid && bus.e_valid && (bus.poly_idx == bus.e_idx) && pidx < DEPTH && pidx != exp_i)
        m_err = 1;
      if (jn) begin
        top = bus.poly_in[2];
        c = (pidx == 0) ? '0 : prev_top;
        if (pidx == 0) m_mode = bus.mode_in;
        if (m_mode) begin
          r0 = bus.b_in[0] - bus.poly_in[0] - c;
          r1 = bus.b_in[1] - bus.poly_in[1];
        end else begin
          r0 = bus.b_in[0] + bus.poly_in[0] + bus.e_in[0] + c;
          r1 = bus.b_in[1] + bus.poly_in[1] + bus.e_in[1];
        end
`ifdef NEGWRAP_EN
        if (pidx == 0) held = mk(0, r0, r1, 1);
        else begin
          q.push_back(mk(pidx, r0, r1, 0));
          if (pidx == DEPTH - 1) begin
            held.l0 = m_mode ? held.l0 + top : held.l0 - top;
            q.push_back(held);
            flush_blk = 1;
          end
        end
`else
        q.push_back(mk(pidx, r0, r1, pidx == DEPTH - 1));
`endif
        prev_top = top;
        exp_i = (pidx == DEPTH - 1) ? 0 : pidx + 1;
      end
    end
  end

  task automatic send(input int idx, input c_t p0, input c_t p1, input c_t top,
                      input c_t e0, input c_t e1, input c_t b0, input c_t b1, input bit m);
    int n = 0;
    bus.poly_valid = 1'b1; bus.e_valid = 1'b1; bus.b_valid = 1'b1;
    bus.poly_idx = 10'(idx); bus.e_idx = 10'(idx);
    bus.poly_in = {top, p1, p0}; bus.e_in = {e1, e0}; bus.b_in = {b1, b0};
    bus.mode_in = m;
    forever begin
      @(negedge clk);
      if (bus.poly_ready && bus.e_ready && bus.b_ready) break;
      n++;
      if (n > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout idx=%0d got=no_accept want=accept", idx);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.poly_valid = 1'b0; bus.e_valid = 1'b0; bus.b_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 || bus.sum_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_drain got=pending want=empty", nm);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0, d0;
    idle();
    bus.mode_in = 1'b0; bus.sum_ready = 1'b1;
    bus.poly_in = '0; bus.e_in = '0; bus.b_in = '0; bus.e_idx = '0;
    bus.poly_valid = 1'b1; bus.poly_idx = 10'd4;
    #12;
    chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_sum_idx", 32'(bus.sum_idx), 32'd0);
    chk("rst_poly_done", 32'(bus.poly_done), 32'd0);
    chk("rst_idx_err", 32'(bus.idx_err), 32'd0);
    chk("rst_poly_ready", 32'(bus.poly_ready), 32'd0);
    idle();
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: plain add stream
    ord_q.delete();
    for (int i = 0; i < 4; i++) send(i, 1, 1, 0, 3, 3, 2, 2, 0);
    idle(); wait_drain("t1");
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_l0_0", 32'(log_l0[0]), 32'd6);
    chk("t1_l1_3", 32'(log_l1[3]), 32'd6);
    chk("t1_count", 32'(ord_q.size()), 32'd4);
`ifdef NEGWRAP_EN
    chk("t1_ord0", 32'(ord_q[0]), 32'd1);
    chk("t1_ord3", 32'(ord_q[3]), 32'd0);
`else
    chk("t1_ord0", 32'(ord_q[0]), 32'd0);
    chk("t1_ord3", 32'(ord_q[3]), 32'd3);
`endif

    // 2: overlap carry from beat 0 into beat 1
    send(0, 0, 0, 5, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) send(i, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); wait_drain("t2");
    chk("t2_l0_1", 32'(log_l0[1]), 32'd5);
    chk("t2_l1_1", 32'(log_l1[1]), 32'd0);
    chk("t2_l0_0", 32'(log_l0[0]), 32'd0);

    // 3: subtract mode, e ignored
    for (int i = 0; i < 4; i++) send(i, 1, 1, 0, 7, 7, 0, 0, 1);
    idle(); wait_drain("t3");
    chk("t3_l0_0", 32'(log_l0[0]), 32'h3FFFF);
    chk("t3_l1_1", 32'(log_l1[1]), 32'h3FFFF);
    chk("t3_l0_3", 32'(log_l0[3]), 32'h3FFFF);

    // 4: downstream stall mid-stream
    hs0 = hs_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(i, c_t'(i * 10), c_t'(i * 10 + 1), c_t'(i), 1, 1, 100, 100, 0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.sum_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall_ready", 32'(bus.poly_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 bus.sum_ready = 1'b1;
      end
    join
    wait_drain("t4");
    chk("t4_count", 32'(hs_cnt - hs0), 32'd4);
    chk("t4_l0_2", 32'(log_l0[2]), 32'd122);
    chk("t4_l1_3", 32'(log_l1[3]), 32'd132);
`ifdef NEGWRAP_EN
    chk("t4_l0_0", 32'(log_l0[0]), 32'd98);
`else
    chk("t4_l0_0", 32'(log_l0[0]), 32'd101);
`endif

    // 6: final overlap lane, wrapped or discarded
    ord_q.delete();
    for (int i = 0; i < 4; i++) send(i, 0, 0, (i == 3) ? c_t'(7) : c_t'(0), 0, 0, 0, 0, 0);
    idle(); wait_drain("t6");
    chk("t6_l1_0", 32'(log_l1[0]), 32'd0);
`ifdef NEGWRAP_EN
    chk("t6_ord0", 32'(ord_q[0]), 32'd1);
    chk("t6_ord3", 32'(ord_q[3]), 32'd0);
    chk("t6_l0_0", 32'(log_l0[0]), 32'h3FFF9);
`else
    chk("t6_ord0", 32'(ord_q[0]), 32'd0);
    chk("t6_ord3", 32'(ord_q[3]), 32'd3);
    chk("t6_l0_0", 32'(log_l0[0]), 32'd0);
`endif

    // 5: drain of out-of-range beat, then index mismatch
    bus.poly_valid = 1'b1; bus.poly_idx = 10'd4; bus.e_idx = 10'd0;
    @(negedge clk);
    chk("t5_drain_ready", 32'(bus.poly_ready), 32'd1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("t5_no_sum", 32'(bus.sum_valid), 32'd0);
    @(posedge clk); #1;
    send(0, 1, 1, 0, 0, 0, 0, 0, 0);
    bus.poly_valid = 1'b1; bus.e_valid = 1'b1; bus.b_valid = 1'b1;
    bus.poly_idx = 10'd2; bus.e_idx = 10'd2;
    repeat (3) begin
      @(negedge clk);
      chk("t5_mis_ready", 32'(bus.poly_ready | bus.e_ready | bus.b_ready), 32'd0);
    end
    chk("t5_err_set", 32'(bus.idx_err), 32'd1);
    @(posedge clk); #1 idle();
    repeat (2) @(negedge clk);
    chk("t5_err_sticky", 32'(bus.idx_err), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t5_err_clr", 32'(bus.idx_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // reset mid-stream with a held result
    bus.sum_ready = 1'b0;
    send(0, 1, 1, 0, 3, 3, 2, 2, 0);
`ifdef NEGWRAP_EN
    send(1, 1, 1, 0, 3, 3, 2, 2, 0);
`endif
    idle();
    @(negedge clk);
    chk("rst_pre_valid", 32'(bus.sum_valid), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(bus.sum_valid), 32'd0);
    chk("rst_drop_sum", 32'(bus.sum), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; bus.sum_ready = 1'b1;

    ord_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) send(i, 1, 1, 0, 3, 3, 2, 2, 0);
    idle(); wait_drain("post_rst");
    chk("post_rst_count", 32'(ord_q.size()), 32'd4);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
    chk("post_rst_l0_1", 32'(log_l0[1]), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
